// File: rtl/rom_sweep_checker_if.sv
// Shared ROM read bus: one address out, two data words back
// (golden and netlist instance).
interface rom_sweep_checker_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_a;
    logic [DATA_W-1:0] data_b;

    modport master (
        output address,
        input  data_a,
        input  data_b
    );

    modport slave (
        input  address,
        output data_a,
        output data_b
    );
endinterface

// File: rtl/rom_sweep_checker.sv
// Sweeps every ROM address, compares golden vs netlist data after the
// read latency, and reports mismatch count, first error and checksum.
module rom_sweep_checker #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    rom_sweep_checker_if.master  rom,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     mismatch_cnt,
    output logic                 first_err_vld,
    output logic [ADDR_W-1:0]    first_err_addr,
    output logic [15:0]          checksum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [2:0] DRAIN_LAST =
        (RD_LAT > 0) ? 3'(RD_LAT - 1) : 3'd0;

    state_t            state;
    state_t            state_n;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        dcnt;
    logic              pass_q;
    logic              issue;
    logic              cmp_v;
    logic [ADDR_W-1:0] cmp_a;
    logic [15:0]       da16;
    logic              accept;

    assign issue       = (state == S_ISSUE);
    assign accept      = (state == S_IDLE) && start;
    assign rom.address = addr;
    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign pass        = done ? (mismatch_cnt == '0) : pass_q;

    generate
        if (DATA_W >= 16) begin : g_trunc
            assign da16 = rom.data_a[15:0];
        end else begin : g_zext
            assign da16 = {{(16 - DATA_W){1'b0}}, rom.data_a};
        end
    endgenerate

    // With a combinational ROM the live address is the compare slot.
    generate
        if (RD_LAT == 0) begin : g_comb
            assign cmp_v = issue;
            assign cmp_a = addr;
        end else begin : g_pipe
            logic [RD_LAT-1:0] sv;
            logic [ADDR_W-1:0] sa [RD_LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    sv <= '0;
                    for (int i = 0; i < RD_LAT; i++) sa[i] <= '0;
                end else begin
                    sv[0] <= issue;
                    sa[0] <= addr;
                    for (int i = 1; i < RD_LAT; i++) begin
                        sv[i] <= sv[i-1];
                        sa[i] <= sa[i-1];
                    end
                end
            end

            assign cmp_v = sv[RD_LAT-1];
            assign cmp_a = sa[RD_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE:  if (start) state_n = S_ISSUE;
            S_ISSUE: if (addr == '1)
                         state_n = (RD_LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (dcnt == DRAIN_LAST) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dcnt <= '0;
        else if (state == S_DRAIN) dcnt <= dcnt + 3'd1;
        else dcnt <= '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr           <= '0;
            mismatch_cnt   <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
            checksum       <= '0;
            pass_q         <= 1'b0;
        end else if (accept) begin
            addr           <= '0;
            mismatch_cnt   <= '0;
            first_err_vld  <= 1'b0;
            first_err_addr <= '0;
            checksum       <= '0;
            pass_q         <= 1'b0;
        end else begin
            if (issue && addr != '1) addr <= addr + 1'b1;
            if (cmp_v) begin
                checksum <= checksum + da16;
                if (rom.data_a != rom.data_b) begin
                    if (mismatch_cnt != '1)
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                    if (!first_err_vld) begin
                        first_err_vld  <= 1'b1;
                        first_err_addr <= cmp_a;
                    end
                end
            end
            if (state == S_DONE) pass_q <= (mismatch_cnt == '0);
        end
    end

endmodule
